uart_tx_controller: RTL and testbench

- UART transmitter; the transmit-side counterpart of the 16x-oversampling receive path.
- Serialises one byte per request onto TxD: start bit, 8 data bits LSB first, optional even parity, stop bit.
- Contains its own baud tick generator, using the same baud_select encoding and 16x tick divisors as the receiver.
- Sits between the system/loopback logic and the TxD pin; the receiver on the far end samples the line.

---
 rtl/uart_tx_if.sv | 21 ++
 rtl/uart_tx_controller.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_controller.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Transmit-side handshake bundle between the system/loopback logic and the UART transmitter.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [2:0]            baud_select;
  logic                  Tx_EN;
  logic                  Tx_WR;
  logic [DATA_WIDTH-1:0] Tx_DATA;
  logic                  TxD;
  logic                  Tx_BUSY;

  modport master (
    output baud_select, Tx_EN, Tx_WR, Tx_DATA,
    input  TxD, Tx_BUSY
  );

  modport slave (
    input  baud_select, Tx_EN, Tx_WR, Tx_DATA,
    output TxD, Tx_BUSY
  );
endinterface

// File: rtl/uart_tx_controller.sv
// UART transmitter with 16x tick generator: start, 8 data bits LSB first, [even parity], stop.
// Optional parity bit is enabled by defining UART_TX_PARITY_EN.
//
// state  | meaning
// IDLE   | line high, waiting for Tx_WR with Tx_EN
// START  | driving start bit (low) for OVERSAMPLE ticks
// DATA   | driving data[bit_idx], one bit per OVERSAMPLE ticks
// PARITY | driving even parity of latched byte (UART_TX_PARITY_EN only)
// STOP   | driving stop bit (high), then back to IDLE
module uart_tx_controller #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic      Clk,
  input  logic      reset,
  uart_tx_if.slave  bus
);

  localparam int BT_W  = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [BT_W-1:0]  BT_LAST  = BT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state, state_n;
  logic [13:0]           tick_cnt, tick_cnt_n;
  logic [BT_W-1:0]       bit_tick, bit_tick_n;
  logic [IDX_W-1:0]      bit_idx, bit_idx_n;
  logic [DATA_WIDTH-1:0] data_reg, data_n;
  logic [2:0]            baud_reg, baud_n;
  logic                  txd_q, txd_n;
  logic                  busy_q, busy_n;
  logic                  tick, bit_done;
  logic [13:0]           divisor;
`ifdef UART_TX_PARITY_EN
  logic                  parity_reg, parity_n;
`endif

  // Clocks per 16x tick at 50 MHz, same table as the receiver.
  always_comb begin
    case (baud_reg)
      3'b000:  divisor = 14'd10416;
      3'b001:  divisor = 14'd2604;
      3'b010:  divisor = 14'd651;
      3'b011:  divisor = 14'd325;
      3'b100:  divisor = 14'd162;
      3'b101:  divisor = 14'd81;
      3'b110:  divisor = 14'd54;
      default: divisor = 14'd27;
    endcase
  end

  assign tick     = (tick_cnt == divisor - 14'd1);
  assign bit_done = tick && (bit_tick == BT_LAST);

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_tick_n = bit_tick;
    bit_idx_n  = bit_idx;
    data_n     = data_reg;
    baud_n     = baud_reg;
`ifdef UART_TX_PARITY_EN
    parity_n   = parity_reg;
`endif

    if (state == IDLE) begin
      tick_cnt_n = '0;
      bit_tick_n = '0;
      bit_idx_n  = '0;
      if (bus.Tx_EN && bus.Tx_WR) begin
        state_n = START;
        data_n  = bus.Tx_DATA;
        baud_n  = bus.baud_select;
`ifdef UART_TX_PARITY_EN
        parity_n = ^bus.Tx_DATA;
`endif
      end
    end else if (!bus.Tx_EN) begin
      // Abort: drop the frame and return the line to idle.
      state_n    = IDLE;
      tick_cnt_n = '0;
      bit_tick_n = '0;
      bit_idx_n  = '0;
    end else begin
      tick_cnt_n = tick ? '0 : tick_cnt + 14'd1;
      if (tick)
        bit_tick_n = bit_done ? '0 : bit_tick + 1'b1;
      if (bit_done) begin
        case (state)
          START: begin
            state_n   = DATA;
            bit_idx_n = '0;
          end
          DATA: begin
            if (bit_idx == IDX_LAST) begin
              bit_idx_n = '0;
`ifdef UART_TX_PARITY_EN
              state_n   = PARITY;
`else
              state_n   = STOP;
`endif
            end else begin
              bit_idx_n = bit_idx + 1'b1;
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: state_n = STOP;
`endif
          STOP:    state_n = IDLE;
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // Outputs are registered from the next state so TxD/Tx_BUSY line up with the state register.
  always_comb begin
    txd_n  = 1'b1;
    busy_n = (state_n != IDLE);
    case (state_n)
      START:  txd_n = 1'b0;
      DATA:   txd_n = data_n[bit_idx_n];
`ifdef UART_TX_PARITY_EN
      PARITY: txd_n = parity_n;
`endif
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_tick <= '0;
      bit_idx  <= '0;
      data_reg <= '0;
      baud_reg <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_tick <= bit_tick_n;
      bit_idx  <= bit_idx_n;
      data_reg <= data_n;
      baud_reg <= baud_n;
      txd_q    <= txd_n;
      busy_q   <= busy_n;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_n;
`endif
    end
  end

  assign bus.TxD     = txd_q;
  assign bus.Tx_BUSY = busy_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed self-checking bench for uart_tx_controller; honours UART_TX_PARITY_EN if defined.
module tb_uart_tx_controller;

  localparam int BIT = 432;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CLKS = NBITS * BIT;

  logic Clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  uart_tx_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_controller #(.OVERSAMPLE(16), .DATA_WIDTH(8)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 Clk = ~Clk;

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line bits in transmit order, bit 0 = start bit.
  function automatic logic [10:0] mk(input logic [7:0] d, input logic p);
`ifdef UART_TX_PARITY_EN
    return {1'b1, p, d, 1'b0};
`else
    return {p & 1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  // Called right after the accepting edge; samples each bit mid-period and times Tx_BUSY.
  task automatic run_frame(input string tag, input logic [10:0] frame,
                           input int wr_at, input bit wr_keep, input logic [7:0] wr_data);
    int cnt = 0;
    int idx = 0;
    while (bus.Tx_BUSY === 1'b1 && cnt < FRAME_CLKS + 200) begin
      if (cnt == wr_at) begin
        bus.Tx_WR   = 1'b1;
        bus.Tx_DATA = wr_data;
      end else if (cnt == wr_at + 1 && !wr_keep) begin
        bus.Tx_WR = 1'b0;
      end
      if (idx < NBITS && cnt == idx * BIT + BIT / 2) begin
        check($sformatf("%s bit%0d", tag, idx), 32'(bus.TxD), 32'(frame[idx]));
        idx++;
      end
      step(1);
      cnt++;
    end
    check({tag, " busy_len"}, 32'(cnt), 32'(FRAME_CLKS));
  endtask

  task automatic start_frame(input logic [7:0] d);
    bus.Tx_DATA = d;
    bus.Tx_WR   = 1'b1;
    step(1);
    bus.Tx_WR   = 1'b0;
  endtask

  initial begin
    int bad;
    bus.baud_select = 3'b111;
    bus.Tx_EN       = 1'b0;
    bus.Tx_WR       = 1'b0;
    bus.Tx_DATA     = 8'h00;
    step(3);
    check("reset txd", 32'(bus.TxD), 32'd1);
    check("reset busy", 32'(bus.Tx_BUSY), 32'd0);
    reset = 1'b1;
    step(1);

    // Strobe with enable low is ignored.
    bus.Tx_WR = 1'b1;
    bus.Tx_DATA = 8'hA5;
    step(3);
    check("wr_no_en busy", 32'(bus.Tx_BUSY), 32'd0);
    check("wr_no_en txd", 32'(bus.TxD), 32'd1);
    bus.Tx_WR = 1'b0;
    bus.Tx_EN = 1'b1;
    step(2);

    // 0xA5 at 115200: 4 ones -> parity 0.
    start_frame(8'hA5);
    check("a5 first busy", 32'(bus.Tx_BUSY), 32'd1);
    check("a5 first txd", 32'(bus.TxD), 32'd0);
    run_frame("a5", mk(8'hA5, 1'b0), -1, 1'b0, 8'h00);
    check("a5 idle txd", 32'(bus.TxD), 32'd1);
    step(5);

    // 0x3C with an ignored 0xFF strobe mid-frame.
    start_frame(8'h3C);
    run_frame("3c", mk(8'h3C, 1'b0), 1000, 1'b0, 8'hFF);
    step(5);

    // 0x5A with Tx_WR held high through the stop bit; 0x96 follows after one idle clock.
    start_frame(8'h5A);
    run_frame("5a", mk(8'h5A, 1'b0), 4000, 1'b1, 8'h96);
    check("b2b gap busy", 32'(bus.Tx_BUSY), 32'd0);
    step(1);
    check("b2b next busy", 32'(bus.Tx_BUSY), 32'd1);
    check("b2b next txd", 32'(bus.TxD), 32'd0);
    bus.Tx_WR = 1'b0;
    bus.baud_select = 3'b000;   // mid-frame change, must not affect 0x96
    run_frame("96", mk(8'h96, 1'b0), -1, 1'b0, 8'h00);
    step(3);

    // Next frame picks up 300 baud: start bit still low long after 432 clocks.
    start_frame(8'h01);
    step(3000);
    check("300 start txd", 32'(bus.TxD), 32'd0);
    check("300 start busy", 32'(bus.Tx_BUSY), 32'd1);
    bus.Tx_EN = 1'b0;
    step(1);
    check("300 abort txd", 32'(bus.TxD), 32'd1);
    check("300 abort busy", 32'(bus.Tx_BUSY), 32'd0);
    bus.Tx_EN = 1'b1;
    step(2);

    // 9600: 5200 clocks per bit; 0x01 -> bit0 high, bit1 low.
    bus.baud_select = 3'b011;
    start_frame(8'h01);
    step(5199);
    check("9600 start end", 32'(bus.TxD), 32'd0);
    step(1);
    check("9600 bit0 begin", 32'(bus.TxD), 32'd1);
    step(5199);
    check("9600 bit0 end", 32'(bus.TxD), 32'd1);
    step(1);
    check("9600 bit1 begin", 32'(bus.TxD), 32'd0);
    bus.Tx_EN = 1'b0;
    step(1);
    bus.Tx_EN = 1'b1;
    bus.baud_select = 3'b111;
    step(2);

    // Enable dropped during data bit 3, then a clean 0x07 frame (3 ones -> parity 1).
    start_frame(8'h00);
    step(4 * BIT + 200);
    check("en_drop pre txd", 32'(bus.TxD), 32'd0);
    bus.Tx_EN = 1'b0;
    step(1);
    check("en_drop txd", 32'(bus.TxD), 32'd1);
    check("en_drop busy", 32'(bus.Tx_BUSY), 32'd0);
    bus.Tx_EN = 1'b1;
    step(1);
    start_frame(8'h07);
    run_frame("07", mk(8'h07, 1'b1), -1, 1'b0, 8'h00);
    step(3);

    // Asynchronous reset during data bits.
    start_frame(8'h00);
    step(3 * BIT + 100);
    check("rst pre busy", 32'(bus.Tx_BUSY), 32'd1);
    reset = 1'b0;
    #1;
    check("rst async txd", 32'(bus.TxD), 32'd1);
    check("rst async busy", 32'(bus.Tx_BUSY), 32'd0);
    step(2);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      step(1);
      if (bus.TxD !== 1'b1 || bus.Tx_BUSY !== 1'b0) bad++;
    end
    check("rst no residue", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
